// File: rtl/mul_share_arb_pkg.sv
// Shared types, default sizes and a small index helper for the mul_share_arb block.
package mul_share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_NREQ  = 4;

  function automatic int wrap_inc(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/serial_mul_core.sv
// Shift-add serial multiplier datapath: one partial product per step, low WIDTH bits kept.
// Early termination is selected by MUL_SHARE_ARB_EARLY_TERM_EN.
module serial_mul_core
  import mul_share_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  localparam int CNTW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [CNTW-1:0]  count;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic [CNTW-1:0]  count_next;

  // Next values of one shift-add step.
  always_comb begin
    if (b[0]) begin
      acc_next = acc + a;
    end else begin
      acc_next = acc;
    end
    a_next     = a << 1;
    b_next     = b >> 1;
    count_next = count + CNTW'(1);
  end

  assign product = acc_next;

`ifdef MUL_SHARE_ARB_EARLY_TERM_EN
  // Once the shifted multiplier is empty no further partial products can contribute.
  assign done = (b_next == '0) || (count == CNTW'(WIDTH - 1));
`else
  assign done = (count == CNTW'(WIDTH - 1));
`endif

  // Datapath registers: cleared on reset, loaded on accept, advanced on each busy step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      a     <= '0;
      b     <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= '0;
      a     <= a_in;
      b     <= b_in;
      count <= '0;
    end else if (step) begin
      acc   <= acc_next;
      a     <= a_next;
      b     <= b_next;
      count <= count_next;
    end else begin
      acc   <= acc;
      a     <= a;
      b     <= b;
      count <= count;
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one serial_mul_core among NREQ requesters.
// Optional early termination: define MUL_SHARE_ARB_EARLY_TERM_EN.
module mul_share_arb
  import mul_share_arb_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = IDXW + 1;

  state_t           state;
  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  index;
  logic [NREQ-1:0]  grant;
  logic [IDXW-1:0]  grant_idx;
  logic             any_valid;
  logic [CW-1:0]    cand;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             load;
  logic             step;
  logic             core_done;
  logic [WIDTH-1:0] product;

  // Round-robin search: first valid requester at or after ptr, wrapping past NREQ-1.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr} + CW'(off);
      if (cand >= CW'(NREQ)) begin
        cand = cand - CW'(NREQ);
      end else begin
        cand = cand;
      end
      if (!any_valid && req_valid[cand]) begin
        any_valid       = 1'b1;
        grant_idx       = cand[IDXW-1:0];
        grant[cand]     = 1'b1;
      end else begin
        any_valid = any_valid;
      end
    end
  end

  // The accept handshake must answer in the same cycle as the request.
  always_comb begin
    if (state == IDLE && !rst) begin
      req_ready = grant;
    end else begin
      req_ready = '0;
    end
  end

  assign sel_a = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_b = req_b[int'(grant_idx)*WIDTH +: WIDTH];
  assign load  = (state == IDLE) && any_valid;
  assign step  = (state == BUSY);

  serial_mul_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .a_in    (sel_a),
    .b_in    (sel_b),
    .product (product),
    .done    (core_done)
  );

  // Control FSM with registered response and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      index      <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid  <= '0;
          rsp_result <= '0;
          if (any_valid) begin
            state <= BUSY;
            index <= grant_idx;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        BUSY: begin
          if (core_done) begin
            state      <= DONE;
            rsp_valid  <= NREQ'(1'b1) << index;
            rsp_result <= product;
          end else begin
            state <= BUSY;
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          rsp_valid  <= '0;
          rsp_result <= '0;
          ptr        <= IDXW'(wrap_inc(int'(index), NREQ));
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          rsp_valid  <= '0;
          rsp_result <= '0;
        end
      endcase
    end
  end

endmodule
